// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 6-stage pipeline
// (PC, IF, ID, EX, MEM, WB).
//
// It merges the per-stage stall requests into one stall vector. It
// sequences exception flushes and supplies the redirect PC. An exception
// that arrives while a data-bus transaction is outstanding is held back
// until the bus goes idle. A watchdog flags pipelines that stay stalled
// for too long.
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   rst               synchronous active-high reset
//   stallreq_from_if  instruction bus not ready
//   stallreq_from_id  load-use hazard
//   stallreq_from_ex  multi-cycle EX operation busy
//   stallreq_from_mem data bus not ready
//   mem_bus_busy      data-bus transaction outstanding
//   excepttype[31:0]  exception code from MEM (0 = none, 0xe = ERET)
//   cp0_epc[31:0]     current EPC from CP0
//   stall[5:0]        per-stage stop (bit0 = PC ... bit5 = WB)
//   flush             clear every pipeline register this cycle
//   new_pc[31:0]      redirect target, meaningful only while flush = 1
//   stall_timeout     sticky watchdog flag
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
  parameter int          CNT_W       = 8,
  parameter int          STALL_LIMIT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        mem_bus_busy,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  localparam logic [31:0]      ERET_CODE = 32'h0000000e;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_BUS = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      exc_lat_reg, epc_lat_reg;
  logic             latch_en;
  logic [5:0]       prio_stall;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_inc;
  logic             timeout_reg;

  // Priority encoding of the stall requests. A stage that stalls also
  // freezes every stage in front of it. An IF stall holds ID too, so that
  // the instruction waiting in ID is not lost.
  always_comb begin
    if (stallreq_from_mem)
      prio_stall = 6'b011111;
    else if (stallreq_from_ex)
      prio_stall = 6'b001111;
    else if (stallreq_from_id || stallreq_from_if)
      prio_stall = 6'b000111;
    else
      prio_stall = 6'b000000;
  end

  // Next state and outputs. While reset is asserted, every output is forced to 0.
  always_comb begin
    state_next = state_reg;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    latch_en   = 1'b0;
    if (!rst) begin
      unique case (state_reg)
        RUN: begin
          if (excepttype != 32'h0) begin
            if (mem_bus_busy) begin
              // The bus cycle cannot be abandoned. Freeze everything and
              // remember the exception until the bus finishes.
              stall      = 6'b111111;
              latch_en   = 1'b1;
              state_next = WAIT_BUS;
            end else begin
              flush      = 1'b1;
              new_pc     = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
              state_next = HOLD;
            end
          end else begin
            stall = prio_stall;
          end
        end
        WAIT_BUS: begin
          if (mem_bus_busy) begin
            stall = 6'b111111;
          end else begin
            flush      = 1'b1;
            new_pc     = (exc_lat_reg == ERET_CODE) ? epc_lat_reg : EXC_VECTOR;
            state_next = HOLD;
          end
        end
        HOLD: begin
          // MEM still holds the instruction that was flushed, so its
          // exception code is stale and is ignored for this cycle.
          stall      = prio_stall;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      exc_lat_reg <= 32'h0;
      epc_lat_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        exc_lat_reg <= excepttype;
        epc_lat_reg <= cp0_epc;
      end
    end
  end

  // Watchdog. It counts consecutive cycles that are stalled and not flushing.
  assign stall_cnt_inc = (stall_cnt_reg == CNT_MAX) ? CNT_MAX
                                                    : stall_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else if ((stall != 6'b000000) && !flush) begin
      stall_cnt_reg <= stall_cnt_inc;
      if (stall_cnt_inc == LIMIT)
        timeout_reg <= 1'b1;
    end else begin
      stall_cnt_reg <= '0;
    end
  end

  assign stall_timeout = timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. It first applies a table of directed vectors
// with hand-written expected values. It then applies randomized stimulus
// and checks it against a behavioural model. Prints one line per cycle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
  logic        mem_bus_busy;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR (32'h00000020),
    .CNT_W      (8),
    .STALL_LIMIT(5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .mem_bus_busy     (mem_bus_busy),
    .excepttype       (excepttype),
    .cp0_epc          (cp0_epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout)
  );

  typedef struct {
    logic        rst, ifr, idr, exr, memr, busy;
    logic [31:0] exc, epc;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        to;
  } vec_t;

  vec_t tbl[$];

  // The behavioural model. It tracks a pending exception, whether the
  // previous cycle flushed, and the length of the current stall run.
  bit          m_pending     = 1'b0;
  logic [31:0] m_code        = 32'h0;
  logic [31:0] m_epc         = 32'h0;
  bit          m_after_flush = 1'b0;
  int          m_run         = 0;
  bit          m_to          = 1'b0;
  logic [5:0]  m_stall;
  logic        m_flush;
  logic [31:0] m_pc;

  function automatic vec_t mk(input logic r, input logic i, input logic d,
                              input logic e, input logic m, input logic b,
                              input logic [31:0] exc, input logic [31:0] epc,
                              input logic [5:0] st, input logic fl,
                              input logic [31:0] pc, input logic to);
    vec_t v;
    v.rst = r; v.ifr = i; v.idr = d; v.exr = e; v.memr = m; v.busy = b;
    v.exc = exc; v.epc = epc; v.st = st; v.fl = fl; v.pc = pc; v.to = to;
    return v;
  endfunction

  function automatic logic [31:0] target(input logic [31:0] code, input logic [31:0] epc);
    return (code == 32'he) ? epc : 32'h20;
  endfunction

  task automatic model_outputs(input vec_t v);
    int n;
    // n is the number of leading stages that are stopped.
    n = v.memr ? 5 : v.exr ? 4 : (v.idr || v.ifr) ? 3 : 0;
    m_stall = 6'((1 << n) - 1);
    m_flush = 1'b0;
    m_pc    = 32'h0;
    if (v.rst) begin
      m_stall = 6'h0;
    end else if (m_pending) begin
      if (v.busy) m_stall = 6'h3f;
      else begin m_stall = 6'h0; m_flush = 1'b1; m_pc = target(m_code, m_epc); end
    end else if (!m_after_flush && v.exc != 32'h0) begin
      if (v.busy) m_stall = 6'h3f;
      else begin m_stall = 6'h0; m_flush = 1'b1; m_pc = target(v.exc, v.epc); end
    end
  endtask

  task automatic model_update(input vec_t v);
    if (v.rst) begin
      m_pending = 1'b0; m_code = 32'h0; m_epc = 32'h0;
      m_after_flush = 1'b0; m_run = 0; m_to = 1'b0;
    end else begin
      if (m_pending && !v.busy) m_pending = 1'b0;
      else if (!m_pending && !m_after_flush && v.exc != 32'h0 && v.busy) begin
        m_pending = 1'b1; m_code = v.exc; m_epc = v.epc;
      end
      m_after_flush = m_flush;
      if (m_stall != 6'h0 && !m_flush) m_run = (m_run < 255) ? m_run + 1 : 255;
      else m_run = 0;
      if (m_run == 5) m_to = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One cycle. Inputs are driven just after the falling edge and outputs
  // are sampled 1 ns later. The model then advances on the rising edge.
  task automatic run_cycle(input vec_t v, input int idx, input bit use_table);
    rst = v.rst; stallreq_from_if = v.ifr; stallreq_from_id = v.idr;
    stallreq_from_ex = v.exr; stallreq_from_mem = v.memr;
    mem_bus_busy = v.busy; excepttype = v.exc; cp0_epc = v.epc;
    #1;
    model_outputs(v);
    $display("cyc %0d rst=%0d req=%b%b%b%b busy=%0d exc=%h stall=%b flush=%0d pc=%h to=%0d",
             idx, v.rst, v.memr, v.exr, v.idr, v.ifr, v.busy, v.exc,
             stall, flush, new_pc, stall_timeout);
    if (use_table) begin
      chk("stall", idx, 32'(stall), 32'(v.st));
      chk("flush", idx, 32'(flush), 32'(v.fl));
      chk("new_pc", idx, new_pc, v.pc);
      chk("timeout", idx, 32'(stall_timeout), 32'(v.to));
    end else begin
      chk("stall", idx, 32'(stall), 32'(m_stall));
      chk("flush", idx, 32'(flush), 32'(m_flush));
      chk("new_pc", idx, new_pc, m_pc);
      chk("timeout", idx, 32'(stall_timeout), 32'(m_to));
    end
    @(posedge clk);
    model_update(v);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    // Reset with everything asserted.
    tbl.push_back(mk(1,1,1,1,1,1, 32'h8, 32'h0, 6'h00,0,32'h0,0));
    tbl.push_back(mk(1,1,1,1,1,1, 32'h8, 32'h0, 6'h00,0,32'h0,0));
    // Stall priority.
    tbl.push_back(mk(0,1,1,1,0,0, 32'h0, 32'h0, 6'h0f,0,32'h0,0));
    tbl.push_back(mk(0,1,1,1,1,0, 32'h0, 32'h0, 6'h1f,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,0));
    // Immediate exception, a dropped follower, then acceptance.
    tbl.push_back(mk(0,0,0,0,0,0, 32'h8, 32'h0, 6'h00,1,32'h20,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'hc, 32'h0, 6'h00,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'hc, 32'h0, 6'h00,1,32'h20,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,0));
    // Deferred ERET. The EPC changes while the exception waits.
    tbl.push_back(mk(0,0,0,0,0,1, 32'he, 32'h1234,     6'h3f,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 32'he, 32'hdead0000, 6'h3f,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 32'he, 32'hdead0000, 6'h3f,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'he, 32'hdead0000, 6'h00,1,32'h1234,0));
    tbl.push_back(mk(0,0,1,0,0,0, 32'h8, 32'h0, 6'h07,0,32'h0,0));  // in HOLD, exc ignored
    // Reset during WAIT_BUS discards the pending exception.
    tbl.push_back(mk(0,0,0,0,0,1, 32'h8, 32'h0, 6'h3f,0,32'h0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 32'h8, 32'h0, 6'h00,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,0));
    // Watchdog: the 5th stalled edge sets the flag and it stays set.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0, 32'h0, 6'h0f,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,1));
    // Two 4-cycle runs separated by a gap never set the flag.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0, 32'h0, 6'h0f,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,1,0,0, 32'h0, 32'h0, 6'h0f,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 6'h00,0,32'h0,0));

    @(negedge clk);
    foreach (tbl[i]) run_cycle(tbl[i], i, 1'b1);

    // Randomized phase against the model.
    for (int i = 0; i < 800; i++) begin
      int sel;
      v.rst  = ($urandom_range(0, 63) == 0);
      v.ifr  = ($urandom_range(0, 2) == 0);
      v.idr  = ($urandom_range(0, 2) == 0);
      v.exr  = ($urandom_range(0, 2) == 0);
      v.memr = ($urandom_range(0, 3) == 0);
      v.busy = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      v.exc = (sel <= 5) ? 32'h0 : (sel == 6) ? 32'h8 : (sel == 7) ? 32'hc :
              (sel == 8) ? 32'he : ($urandom | 32'h1);
      v.epc = $urandom;
      v.st = 6'h0; v.fl = 1'b0; v.pc = 32'h0; v.to = 1'b0;
      run_cycle(v, tbl.size() + i, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
